// File: rtl/la_capture_wb.sv
// Logic-analyser capture engine: DW-bit probe samples into a 2**AW circular buffer, masked
// trigger plus post-trigger count, level IRQ on completion. Optional edge trigger: LA_CAPTURE_EDGE_TRIG_EN.
module la_capture_wb #(
  parameter int          DW       = 32,
  parameter int          AW       = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  input  logic [DW-1:0] sample_i,
  input  logic          sample_en_i,
  output logic          irq_o
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_trig_ptr;
  logic [AW-1:0] r_post_cnt;
  logic [AW-1:0] r_post_left;
  logic          r_wrapped;
  logic          r_irq;
  logic [DW-1:0] r_trig_val;
  logic [DW-1:0] r_trig_mask;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_mem_rd;

  logic          r_busy;
  logic          r_p1_vld;
  logic          r_p1_rd;
  logic          r_p1_buf;
  logic          r_p1_reg;
  logic [2:0]    r_p1_idx;
  logic          r_ack;
  logic [31:0]   r_dat;

  logic          w_req;
  logic          w_new;
  logic          w_wr_reg;
  logic          w_reg_hit;
  logic          w_buf_hit;
  logic [2:0]    w_idx;
  logic [AW-1:0] w_buf_idx;
  logic          w_arm;
  logic          w_abort;
  logic          w_level;
  logic          w_trig;
  logic          w_capturing;
  logic          w_mem_we;
  logic [31:0]   w_post_m;
  logic [31:0]   w_rd_val;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
    for (int b = 0; b < 4; b++)
      f_merge[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
  endfunction

  // A request is taken once; r_busy blocks re-acking until stb has dropped for a cycle.
  assign w_req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_ADR[31:16]);
  assign w_new     = w_req & ~r_busy;
  assign w_reg_hit = (wbs_adr_i[15:5] == 11'd0);
  assign w_buf_hit = wbs_adr_i[15] && ((wbs_adr_i[14:0] >> (AW + 2)) == 15'd0);
  assign w_idx     = wbs_adr_i[4:2];
  assign w_buf_idx = wbs_adr_i[AW+1:2];
  assign w_wr_reg  = w_new & wbs_we_i & w_reg_hit;
  assign w_arm     = w_wr_reg && (w_idx == 3'd0) && wbs_sel_i[0] && wbs_dat_i[0];
  assign w_abort   = w_wr_reg && (w_idx == 3'd0) && wbs_sel_i[0] && wbs_dat_i[1];
  assign w_post_m  = f_merge(32'(r_post_cnt), wbs_dat_i, wbs_sel_i);

  assign w_level   = (((sample_i ^ r_trig_val) & r_trig_mask) == '0);

`ifdef LA_CAPTURE_EDGE_TRIG_EN
  logic          r_mode_edge;
  logic          r_first;
  logic [DW-1:0] r_prev;
  logic [DW-1:0] w_chg;

  assign w_chg  = (sample_i ^ r_prev) & r_trig_mask;
  assign w_trig = r_mode_edge ? (!r_first && (w_chg != '0) && (((sample_i ^ r_trig_val) & w_chg) == '0))
                              : w_level;
`else
  assign w_trig = w_level;
`endif

  assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_mem_we    = sample_en_i && w_capturing && !w_arm && !w_abort;

  always_ff @(posedge wb_clk_i) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= sample_i;
    r_mem_rd <= r_mem[w_buf_idx];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_trig_ptr  <= '0;
      r_post_cnt  <= '0;
      r_post_left <= '0;
      r_wrapped   <= 1'b0;
      r_irq       <= 1'b0;
      r_trig_val  <= '0;
      r_trig_mask <= '0;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
      r_mode_edge <= 1'b0;
      r_first     <= 1'b0;
      r_prev      <= '0;
`endif
    end else begin
      if (w_wr_reg && w_idx == 3'd2)
        r_trig_val <= DW'(f_merge(32'(r_trig_val), wbs_dat_i, wbs_sel_i));
      if (w_wr_reg && w_idx == 3'd3)
        r_trig_mask <= DW'(f_merge(32'(r_trig_mask), wbs_dat_i, wbs_sel_i));
      if (w_wr_reg && w_idx == 3'd4)
        r_post_cnt <= (w_post_m > 32'(DEPTH - 1)) ? AW'(DEPTH - 1) : AW'(w_post_m);
`ifdef LA_CAPTURE_EDGE_TRIG_EN
      if (w_wr_reg && w_idx == 3'd7 && wbs_sel_i[0])
        r_mode_edge <= wbs_dat_i[0];
      if (sample_en_i) begin
        r_prev  <= sample_i;
        r_first <= 1'b0;
      end
      if (w_arm && !w_abort)
        r_first <= 1'b1;
`endif
      if (w_abort) begin
        r_state <= S_IDLE;
        r_irq   <= 1'b0;
      end else if (w_arm) begin
        r_state   <= S_ARMED;
        r_wr_ptr  <= '0;
        r_wrapped <= 1'b0;
        r_irq     <= 1'b0;
      end else if (w_mem_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_wr_ptr == AW'(DEPTH - 1)) r_wrapped <= 1'b1;
        if (r_state == S_ARMED) begin
          if (w_trig) begin
            r_trig_ptr  <= r_wr_ptr;
            r_post_left <= r_post_cnt;
            if (r_post_cnt == '0) begin
              r_state <= S_DONE;
              r_irq   <= 1'b1;
            end else begin
              r_state <= S_POST;
            end
          end
        end else begin
          r_post_left <= r_post_left - AW'(1);
          if (r_post_left == AW'(1)) begin
            r_state <= S_DONE;
            r_irq   <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (r_p1_buf) begin
      w_rd_val = 32'(r_mem_rd);
    end else if (r_p1_reg) begin
      case (r_p1_idx)
        3'd1:    w_rd_val = {28'd0, r_irq, r_wrapped, r_state};
        3'd2:    w_rd_val = 32'(r_trig_val);
        3'd3:    w_rd_val = 32'(r_trig_mask);
        3'd4:    w_rd_val = 32'(r_post_cnt);
        3'd5:    w_rd_val = 32'(r_trig_ptr);
        3'd6:    w_rd_val = 32'(r_wr_ptr);
`ifdef LA_CAPTURE_EDGE_TRIG_EN
        3'd7:    w_rd_val = {31'd0, r_mode_edge};
`endif
        default: w_rd_val = '0;
      endcase
    end
  end

  // Two-stage read pipe: stage 1 captures the decode and the RAM word, stage 2 drives ack/data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_busy   <= 1'b0;
      r_p1_vld <= 1'b0;
      r_p1_rd  <= 1'b0;
      r_p1_buf <= 1'b0;
      r_p1_reg <= 1'b0;
      r_p1_idx <= '0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_busy   <= w_req;
      r_p1_vld <= w_new;
      r_p1_rd  <= w_new & ~wbs_we_i;
      r_p1_buf <= w_buf_hit;
      r_p1_reg <= w_reg_hit;
      r_p1_idx <= w_idx;
      r_ack    <= r_p1_vld;
      r_dat    <= (r_p1_vld && r_p1_rd) ? w_rd_val : 32'd0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_la_capture_wb.sv
// Randomised and directed bench for la_capture_wb against a behavioural capture model.
module tb_la_capture_wb;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dati = '0;
  logic [31:0] dato;
  logic        ack;
  logic [DW-1:0] smp = '0;
  logic        smp_en = 1'b0;
  logic        irq;

  int total = 0;
  int bad = 0;

  // behavioural model
  int          m_state, m_wr, m_trig, m_left;
  bit          m_wrapped, m_irq;
  logic [31:0] m_val, m_mask;
  int          m_post;
  logic [31:0] m_buf [DEPTH];
  bit          m_touched [DEPTH];
  logic [31:0] q_s [$];
  bit          q_e [$];

  la_capture_wb #(.DW(DW), .AW(AW), .BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dati), .wbs_dat_o(dato), .wbs_ack_o(ack),
    .sample_i(smp), .sample_en_i(smp_en), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_state = 0; m_wr = 0; m_trig = 0; m_left = 0; m_wrapped = 0; m_irq = 0;
    m_val = 0; m_mask = 0; m_post = 0;
  endtask

  task automatic m_arm();
    m_state = 1; m_wr = 0; m_wrapped = 0; m_irq = 0;
    for (int i = 0; i < DEPTH; i++) m_touched[i] = 0;
  endtask

  task automatic m_sample(input logic [31:0] s, input bit en);
    if (!en || !(m_state == 1 || m_state == 2)) return;
    m_buf[m_wr] = s;
    m_touched[m_wr] = 1;
    if (m_state == 1) begin
      if (((s ^ m_val) & m_mask) == 0) begin
        m_trig = m_wr;
        if (m_post == 0) begin m_state = 3; m_irq = 1; end
        else begin m_state = 2; m_left = m_post; end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin m_state = 3; m_irq = 1; end
    end
    m_wr = (m_wr + 1) % DEPTH;
    if (m_wr == 0) m_wrapped = 1;
  endtask

  task automatic wb_cycle(input logic [31:0] a, input bit w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dati = d; sel = s;
    lat = -1; rd = 32'hDEAD_BEEF;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; rd = dato; break; end
    end
    cyc = 0; stb = 0; we = 0;
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL wb_timeout adr=%h: no ack within 8 cycles, ack required", a);
    end
  endtask

  task automatic wb_wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] rd; int lat;
    wb_cycle(BASE + off, 1'b1, d, 4'hF, rd, lat);
  endtask

  task automatic wb_rd(input logic [31:0] off, output logic [31:0] rd);
    int lat;
    wb_cycle(BASE + off, 1'b0, 32'd0, 4'hF, rd, lat);
  endtask

  task automatic setup(input logic [31:0] val, input logic [31:0] mask, input int post);
    wb_wr(32'h08, val); wb_wr(32'h0C, mask); wb_wr(32'h10, post);
    m_val = val; m_mask = mask; m_post = (post > DEPTH - 1) ? DEPTH - 1 : post;
    wb_wr(32'h00, 32'h1);
    m_arm();
  endtask

  // drives queued samples one per cycle, checking irq_o against the model each cycle
  task automatic run_capture();
    for (int i = 0; i < q_s.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (irq !== m_irq) begin bad++; $display("FAIL irq_cycle i=%0d got=%b want=%b", i, irq, m_irq); end
      smp = q_s[i]; smp_en = q_e[i];
      m_sample(q_s[i], q_e[i]);
    end
    @(posedge clk); #1;
    smp_en = 0;
    total++;
    if (irq !== m_irq) begin bad++; $display("FAIL irq_final got=%b want=%b", irq, m_irq); end
    q_s.delete(); q_e.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (irq !== 1'b0 || ack !== 1'b0 || dato !== 32'd0) begin
      bad++; $display("FAIL reset_outputs irq=%b ack=%b dat=%h want 0", irq, ack, dato);
    end
    rst = 0;
    m_reset();
    wb_cycle(BASE + 32'h04, 1'b0, 0, 4'hF, rd, lat);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_status got=%h want=0", rd); end
    total++; if (lat !== 2) begin bad++; $display("FAIL read_latency got=%0d want=2", lat); end
    wb_rd(32'h14, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_trig_ptr got=%h want=0", rd); end
    wb_rd(32'h18, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_wr_ptr got=%h want=0", rd); end
    wb_cycle(BASE + 32'h08, 1'b1, 32'hA5, 4'hF, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL write_latency got=%0d want=2", lat); end
    wb_rd(32'h08, rd);
    total++; if (rd !== 32'hA5) begin bad++; $display("FAIL trig_val_rb got=%h want=a5", rd); end
  endtask

  task automatic test_regs();
    logic [31:0] rd; int lat; int acks;
    wb_wr(32'h0C, 32'h0);
    wb_cycle(BASE + 32'h0C, 1'b1, 32'hFFFF_FFFF, 4'b0101, rd, lat);
    wb_rd(32'h0C, rd);
    total++; if (rd !== 32'h00FF_00FF) begin bad++; $display("FAIL byte_sel got=%h want=00ff00ff", rd); end
    wb_wr(32'h10, 32'h1234);
    wb_rd(32'h10, rd);
    total++; if (rd !== 32'hFF) begin bad++; $display("FAIL post_sat got=%h want=ff", rd); end
    wb_rd(32'h00, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL ctrl_read got=%h want=0", rd); end
    wb_rd(32'h40, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped got=%h want=0", rd); end
    wb_wr(32'h1C, 32'h1);
    wb_rd(32'h1C, rd);
`ifdef LA_CAPTURE_EDGE_TRIG_EN
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL mode_rb got=%h want=1", rd); end
    wb_wr(32'h1C, 32'h0);
`else
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mode_rb got=%h want=0", rd); end
`endif
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 32'h3001_0000;
    acks = 0;
    repeat (5) begin @(posedge clk); #1; if (ack) acks++; end
    cyc = 0; stb = 0;
    total++; if (acks !== 0) begin bad++; $display("FAIL wrong_base acks=%0d want=0", acks); end
  endtask

  task automatic test_level_trigger();
    logic [31:0] rd;
    setup(32'h10, 32'hFF, 3);
    for (int i = 0; i < 48; i++) begin q_s.push_back(i); q_e.push_back(1); end
    run_capture();
    wb_rd(32'h14, rd);
    total++; if (rd !== 32'h10) begin bad++; $display("FAIL lvl_trig_ptr got=%h want=10", rd); end
    wb_rd(32'h18, rd);
    total++; if (rd !== 32'h14) begin bad++; $display("FAIL lvl_wr_ptr got=%h want=14", rd); end
    wb_rd(32'h04, rd);
    total++; if (rd !== 32'hB) begin bad++; $display("FAIL lvl_status got=%h want=b", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_irq got=%b want=1", irq); end
    for (int i = 16; i < 20; i++) begin
      wb_rd(32'h8000 + 4 * i, rd);
      total++; if (rd !== i) begin bad++; $display("FAIL lvl_buf[%0d] got=%h want=%h", i, rd, i); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    setup(300, 32'hFFFF, 0);
    for (int i = 0; i < 311; i++) begin q_s.push_back(i); q_e.push_back(1); end
    run_capture();
    wb_rd(32'h04, rd);
    total++; if (rd !== 32'hF) begin bad++; $display("FAIL wrap_status got=%h want=f", rd); end
    wb_rd(32'h14, rd);
    total++; if (rd !== 44) begin bad++; $display("FAIL wrap_trig_ptr got=%0d want=44", rd); end
    wb_rd(32'h18, rd);
    total++; if (rd !== 45) begin bad++; $display("FAIL wrap_wr_ptr got=%0d want=45", rd); end
    wb_wr(32'h8000 + 4 * 44, 32'h0);
    wb_rd(32'h8000 + 4 * 44, rd);
    total++; if (rd !== 300) begin bad++; $display("FAIL wrap_buf44 got=%0d want=300", rd); end
  endtask

  task automatic test_sample_en();
    logic [31:0] rd;
    setup(5, 32'hFF, 2);
    for (int i = 0; i < 6; i++) begin q_s.push_back(i); q_e.push_back(1); end
    q_s.push_back(6);  q_e.push_back(0);
    q_s.push_back(7);  q_e.push_back(1);
    q_s.push_back(8);  q_e.push_back(0);
    q_s.push_back(9);  q_e.push_back(1);
    q_s.push_back(10); q_e.push_back(1);
    run_capture();
    wb_rd(32'h18, rd);
    total++; if (rd !== 8) begin bad++; $display("FAIL en_wr_ptr got=%0d want=8", rd); end
    wb_rd(32'h8000 + 4 * 6, rd);
    total++; if (rd !== 7) begin bad++; $display("FAIL en_buf6 got=%0d want=7", rd); end
    wb_rd(32'h8000 + 4 * 7, rd);
    total++; if (rd !== 9) begin bad++; $display("FAIL en_buf7 got=%0d want=9", rd); end
    wb_rd(32'h04, rd);
    total++; if (rd !== 32'hB) begin bad++; $display("FAIL en_status got=%h want=b", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    setup(32'hFF, 32'hFF, 0);
    for (int i = 0; i < 4; i++) begin q_s.push_back(i); q_e.push_back(1); end
    run_capture();
    wb_rd(32'h04, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL abort_pre_status got=%h want=1", rd); end
    wb_wr(32'h00, 32'h3);
    m_state = 0; m_irq = 0;
    wb_rd(32'h04, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL abort_status got=%h want=0", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL abort_irq got=%b want=0", irq); end
    wb_rd(32'h18, rd);
    total++; if (rd !== 4) begin bad++; $display("FAIL abort_wr_ptr got=%0d want=4", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int acks;
    setup(2, 32'hFF, 50);
    for (int i = 0; i < 6; i++) begin q_s.push_back(i); q_e.push_back(1); end
    run_capture();
    wb_rd(32'h04, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL mid_post_status got=%h want=2", rd); end
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h04;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    acks = ack ? 1 : 0;
    rst = 0; cyc = 0; stb = 0;
    repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
    total++; if (acks !== 0) begin bad++; $display("FAIL stray_ack acks=%0d want=0", acks); end
    m_reset();
    wb_rd(32'h04, rd);
    total++; if (rd !== 0) begin bad++; $display("FAIL rst_status got=%h want=0", rd); end
    wb_rd(32'h08, rd);
    total++; if (rd !== 0) begin bad++; $display("FAIL rst_trig_val got=%h want=0", rd); end
    wb_rd(32'h0C, rd);
    total++; if (rd !== 0) begin bad++; $display("FAIL rst_mask got=%h want=0", rd); end
    wb_rd(32'h10, rd);
    total++; if (rd !== 0) begin bad++; $display("FAIL rst_post got=%h want=0", rd); end
    wb_rd(32'h18, rd);
    total++; if (rd !== 0) begin bad++; $display("FAIL rst_wr_ptr got=%h want=0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int it = 0; it < 5; it++) begin
      setup($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 40));
      for (int i = 0; i < int'($urandom_range(20, 400)); i++) begin
        q_s.push_back(($urandom & 32'hFFFF_FFF0) | $urandom_range(0, 15));
        q_e.push_back($urandom_range(0, 3) != 0);
      end
      run_capture();
      wb_rd(32'h04, rd);
      total++; if (rd !== {28'd0, m_irq, m_wrapped, 2'(m_state)}) begin
        bad++; $display("FAIL rnd%0d_status got=%h want=%h", it, rd, {28'd0, m_irq, m_wrapped, 2'(m_state)});
      end
      wb_rd(32'h14, rd);
      total++; if (rd !== m_trig) begin bad++; $display("FAIL rnd%0d_trig_ptr got=%0d want=%0d", it, rd, m_trig); end
      wb_rd(32'h18, rd);
      total++; if (rd !== m_wr) begin bad++; $display("FAIL rnd%0d_wr_ptr got=%0d want=%0d", it, rd, m_wr); end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_touched[i]) begin
          wb_rd(32'h8000 + 4 * i, rd);
          total++; if (rd !== m_buf[i]) begin
            bad++; $display("FAIL rnd%0d_buf[%0d] got=%h want=%h", it, i, rd, m_buf[i]);
          end
        end
      end
      if (it == 2) begin
        wb_wr(32'h00, 32'h2);
        m_state = 0; m_irq = 0;
      end
    end
  endtask

`ifdef LA_CAPTURE_EDGE_TRIG_EN
  task automatic test_edge();
    logic [31:0] rd;
    logic [31:0] seq [5];
    bit saw_early;
    seq[0] = 1; seq[1] = 1; seq[2] = 0; seq[3] = 0; seq[4] = 1;
    wb_wr(32'h1C, 32'h1);
    wb_wr(32'h08, 32'h1); wb_wr(32'h0C, 32'h1); wb_wr(32'h10, 32'h0);
    wb_wr(32'h00, 32'h1);
    saw_early = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (irq) saw_early = 1;
      smp = seq[i]; smp_en = 1;
    end
    @(posedge clk); #1;
    smp_en = 0;
    total++; if (saw_early !== 1'b0) begin bad++; $display("FAIL edge_early irq before 5th sample"); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL edge_irq got=%b want=1", irq); end
    wb_rd(32'h14, rd);
    total++; if (rd !== 4) begin bad++; $display("FAIL edge_trig_ptr got=%0d want=4", rd); end
    wb_wr(32'h1C, 32'h0);
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_regs();
    test_level_trigger();
    test_wrap();
    test_sample_en();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef LA_CAPTURE_EDGE_TRIG_EN
    test_edge();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
